marker_overlay: RTL
===================

Name: marker_overlay

Overview:
- Consumer end of the object-position interface.
- Accepts the measured centroid (x_position, y_position, valid_position) and commits it at the next frame boundary.
- Draws a hollow square marker centred on the committed centroid into the outgoing RGB pixel stream.
- Sits between the video pipeline and the display output; pixels pass through unchanged when no object is being tracked.

Parameters:
- INPUT_WIDTH, 11, width of the internal raster x/y counters and committed coordinates.
- COLOR_WIDTH, 10, width of each colour channel.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BOX_HALF, 8, marker half-size in pixels (outline at distance exactly BOX_HALF from centre).
- LOST_FRAMES, 4, consecutive frames without a new position before tracking is dropped.

Ports:
- clk  input  1  system clock
- aresetn  input  1  asynchronous active-low reset
- x_position  input  27  measured centroid x
- y_position  input  27  measured centroid y
- valid_position  input  1  one-cycle strobe qualifying x/y_position
- pixel_valid  input  1  input pixel qualifier
- sof  input  1  start of frame, qualified by pixel_valid; marks pixel (0,0)
- red_in / green_in / blue_in  input  COLOR_WIDTH  input pixel
- red_out / green_out / blue_out  output  COLOR_WIDTH  output pixel
- out_valid  output  1  pixel_valid delayed to match the data
- out_sof  output  1  sof delayed to match the data
- tracking  output  1  high while in the TRACK state
- marker_x / marker_y  output  INPUT_WIDTH  committed marker centre

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on aresetn.
- Reset values: all outputs 0; state IDLE; pending_flag 0; raster counters 0; miss_cnt 0.
- Position capture:
  - On valid_position, the value is in range if x_position < H_ACTIVE and y_position < V_ACTIVE. This also rejects the garbage produced by a zero-count divide upstream.
  - In range: pending <= low INPUT_WIDTH bits of each coordinate; pending_flag <= 1.
  - Out of range: ignored, and pending is unchanged.
  - A later in-range strobe overwrites pending before commit (last value wins).
- Raster counters: advance only on pixel_valid.
  - pixel_valid && sof: the pixel is (0,0); the counters become x=1, y=0.
  - Otherwise x increments. At x == H_ACTIVE-1, x wraps to 0 and y increments. y wraps to 0 after V_ACTIVE-1.
  - A missing sof does not stall the counters.
- Frame commit: on pixel_valid && sof, using the state before this cycle's updates:
  - If pending_flag: marker <= pending; pending_flag <= 0; miss_cnt <= 0; state -> TRACK.
  - Else if TRACK: miss_cnt++. When miss_cnt reaches LOST_FRAMES-1 at this commit, go to IDLE and clear miss_cnt.
  - Else: stay IDLE.
  - valid_position in the same cycle as sof: the commit uses the old pending. The new value is written to pending (pending_flag stays 1) for the next frame.
- State machine: IDLE -> TRACK on a commit with pending; TRACK -> TRACK on a commit with pending; TRACK -> IDLE after LOST_FRAMES empty commits. tracking = (state == TRACK).
- Marker test (stage 1), with dx = x - marker_x and dy = y - marker_y (signed, INPUT_WIDTH+1 bits):
  - hit when TRACK and ((|dx| == BOX_HALF and |dy| <= BOX_HALF) or (|dy| == BOX_HALF and |dx| <= BOX_HALF)).
  - Parts of the box that fall off-screen are clipped naturally. Markers at an edge draw only the on-screen portion; no wrap to the opposite edge.
- Pipeline: 2-cycle fixed latency.
  - Stage 1 registers the pixel, sof, valid and hit.
  - Stage 2 outputs either full-scale green (R=0, G=all ones, B=0) on hit, or the pixel passed through.
  - out_valid and out_sof follow pixel_valid and sof exactly 2 cycles later. No backpressure.
  - Outputs update only when the stage-1 valid is high; otherwise they hold.
- Commit timing: marker_x, marker_y and tracking update on the cycle after the sof commit. The committed marker applies from pixel (0,0) of the committed frame, because the commit takes effect in the hit logic for the sof pixel itself.
- Reset mid-frame: everything clears immediately; the stream resumes pass-through at the next pixel.

Decomposition:
- Shared package: the IDLE/TRACK state encoding, the marker colour constants, and the default H_ACTIVE/V_ACTIVE.
- One sub-module: raster_counter (x/y counters with sof resync and wrap), reusable by the measurement block.

Test Plan:
- Reset, then 2 frames with no valid_position -> output pixels equal input pixels delayed 2 cycles; tracking=0.
- valid_position with (320,240), then a frame -> tracking=1 and marker_x/y=320/240. Pixel (312,240) and pixel (328,235) are green. Pixel (320,240) and pixel (313,241) pass through.
- valid_position with x_position=700 (out of range) -> ignored; state and marker unchanged.
- Marker at (2,3) -> only on-screen outline pixels at x=10 and y=11 are green. No green at x=H_ACTIVE-6.
- After a commit, LOST_FRAMES-1 frames without valid -> still tracking. The next frame without valid -> IDLE and pass-through.
- valid_position (100,100) on the same cycle as sof with pending (50,50) -> this frame uses (50,50); the next frame uses (100,100).

Source files
------------

// File: rtl/marker_overlay_pkg.sv
// Shared definitions for the marker overlay and its raster counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package marker_overlay_pkg;

    // Tracking state: IDLE passes video through, TRACK draws the marker.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } track_state_e;

    // Marker colour as per-channel full-scale enables; the top expands each
    // bit to the configured channel width. Full-scale green.
    localparam logic MARK_RED_ON   = 1'b0;
    localparam logic MARK_GREEN_ON = 1'b1;
    localparam logic MARK_BLUE_ON  = 1'b0;

    // Default active raster size.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/marker_overlay_raster_counter.sv
// Raster x/y position tracker with start-of-frame resync and line/frame wrap.
// Latency: cur_x/cur_y are combinational for the pixel presented this cycle.
// Backpressure: none; advances only on pixel_valid, never stalls.
// Ports: clk, aresetn; pixel_valid/sof in; cur_x/cur_y = position of current pixel.
module marker_overlay_raster_counter
    import marker_overlay_pkg::*;
#(
    parameter int INPUT_WIDTH = 11,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   pixel_valid,
    input  logic                   sof,
    output logic [INPUT_WIDTH-1:0] cur_x,
    output logic [INPUT_WIDTH-1:0] cur_y
);

    localparam logic [INPUT_WIDTH-1:0] X_LAST = INPUT_WIDTH'(H_ACTIVE - 1);
    localparam logic [INPUT_WIDTH-1:0] Y_LAST = INPUT_WIDTH'(V_ACTIVE - 1);

    // cnt_* holds the position of the next expected pixel.
    logic [INPUT_WIDTH-1:0] cnt_x_q, cnt_x_d;
    logic [INPUT_WIDTH-1:0] cnt_y_q, cnt_y_d;

    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (pixel_valid) begin
            if (sof) begin
                // The sof pixel is (0,0), so the next one is (1,0).
                cnt_x_d = INPUT_WIDTH'(1);
                cnt_y_d = '0;
            end else if (cnt_x_q == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (cnt_y_q == Y_LAST) ? '0 : cnt_y_q + 1'b1;
            end else begin
                cnt_x_d = cnt_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else begin
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
        end
    end

    // sof forces (0,0) even if the previous frame was short or long.
    assign cur_x = sof ? '0 : cnt_x_q;
    assign cur_y = sof ? '0 : cnt_y_q;

endmodule

// File: rtl/marker_overlay.sv
// Draws a hollow square marker around the frame-committed object centroid.
// Latency: fixed 2 cycles from pixel in to pixel out.
// Backpressure: none; RGB outputs hold while no valid pixel is in stage 1.
// Ports: x/y_position + valid_position (centroid strobe); pixel_valid, sof,
//        red/green/blue_in (video in); red/green/blue_out, out_valid, out_sof
//        (video out); tracking, marker_x/y (committed marker status).
module marker_overlay
    import marker_overlay_pkg::*;
#(
    parameter int INPUT_WIDTH = 11,
    parameter int COLOR_WIDTH = 10,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int BOX_HALF    = 8,
    parameter int LOST_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [26:0]            x_position,
    input  logic [26:0]            y_position,
    input  logic                   valid_position,
    input  logic                   pixel_valid,
    input  logic                   sof,
    input  logic [COLOR_WIDTH-1:0] red_in,
    input  logic [COLOR_WIDTH-1:0] green_in,
    input  logic [COLOR_WIDTH-1:0] blue_in,
    output logic [COLOR_WIDTH-1:0] red_out,
    output logic [COLOR_WIDTH-1:0] green_out,
    output logic [COLOR_WIDTH-1:0] blue_out,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   tracking,
    output logic [INPUT_WIDTH-1:0] marker_x,
    output logic [INPUT_WIDTH-1:0] marker_y
);

    localparam int MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [MISS_W-1:0]    MISS_LAST = MISS_W'(LOST_FRAMES - 1);
    localparam logic [26:0]          H_LIMIT   = 27'(H_ACTIVE);
    localparam logic [26:0]          V_LIMIT   = 27'(V_ACTIVE);
    localparam logic [INPUT_WIDTH:0] BOX       = (INPUT_WIDTH + 1)'(BOX_HALF);

    localparam logic [COLOR_WIDTH-1:0] MARK_R = {COLOR_WIDTH{MARK_RED_ON}};
    localparam logic [COLOR_WIDTH-1:0] MARK_G = {COLOR_WIDTH{MARK_GREEN_ON}};
    localparam logic [COLOR_WIDTH-1:0] MARK_B = {COLOR_WIDTH{MARK_BLUE_ON}};

    // ---------------- raster position of the incoming pixel ----------------
    logic [INPUT_WIDTH-1:0] cur_x, cur_y;

    marker_overlay_raster_counter #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE)
    ) u_raster_counter (
        .clk         (clk),
        .aresetn     (aresetn),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .cur_x       (cur_x),
        .cur_y       (cur_y)
    );

    // ---------------- capture, commit and tracking state ----------------
    track_state_e           state_q, state_d;
    logic [INPUT_WIDTH-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic                   pend_flag_q, pend_flag_d;
    logic [INPUT_WIDTH-1:0] marker_x_q, marker_x_d, marker_y_q, marker_y_d;
    logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic                   pos_in_range;

    // Also rejects the saturated/garbage result of an upstream divide by zero.
    assign pos_in_range = (x_position < H_LIMIT) && (y_position < V_LIMIT);

    always_comb begin
        state_d     = state_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_flag_d = pend_flag_q;
        marker_x_d  = marker_x_q;
        marker_y_d  = marker_y_q;
        miss_cnt_d  = miss_cnt_q;

        if (pixel_valid && sof) begin
            if (pend_flag_q) begin
                marker_x_d  = pend_x_q;
                marker_y_d  = pend_y_q;
                pend_flag_d = 1'b0;
                miss_cnt_d  = '0;
                state_d     = ST_TRACK;
            end else if (state_q == ST_TRACK) begin
                if (miss_cnt_q == MISS_LAST) begin
                    state_d    = ST_IDLE;
                    miss_cnt_d = '0;
                end else begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
        end

        // Evaluated after the commit so a strobe coinciding with sof lands in
        // pending for the following frame rather than being lost.
        if (valid_position && pos_in_range) begin
            pend_x_d    = x_position[INPUT_WIDTH-1:0];
            pend_y_d    = y_position[INPUT_WIDTH-1:0];
            pend_flag_d = 1'b1;
        end
    end

    // ---------------- marker outline test ----------------
    // Uses the _d values so a commit on the sof pixel already applies to it;
    // on every other pixel _d equals _q. The extra sign bit keeps off-screen
    // box edges from wrapping onto the opposite side of the raster.
    logic [INPUT_WIDTH:0] dx, dy, adx, ady;
    logic                 hit;

    always_comb begin
        dx  = {1'b0, cur_x} - {1'b0, marker_x_d};
        dy  = {1'b0, cur_y} - {1'b0, marker_y_d};
        adx = dx[INPUT_WIDTH] ? (~dx + 1'b1) : dx;
        ady = dy[INPUT_WIDTH] ? (~dy + 1'b1) : dy;
        hit = (state_d == ST_TRACK) &&
              (((adx == BOX) && (ady <= BOX)) || ((ady == BOX) && (adx <= BOX)));
    end

    // ---------------- two-stage video pipeline ----------------
    logic                   s1_vld_q, s1_vld_d, s1_sof_q, s1_sof_d, s1_hit_q, s1_hit_d;
    logic [COLOR_WIDTH-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic                   out_vld_q, out_vld_d, out_sof_q, out_sof_d;
    logic [COLOR_WIDTH-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

    always_comb begin
        s1_vld_d = pixel_valid;
        s1_sof_d = pixel_valid & sof;
        s1_hit_d = s1_hit_q;
        s1_r_d   = s1_r_q;
        s1_g_d   = s1_g_q;
        s1_b_d   = s1_b_q;
        if (pixel_valid) begin
            s1_hit_d = hit;
            s1_r_d   = red_in;
            s1_g_d   = green_in;
            s1_b_d   = blue_in;
        end

        out_vld_d = s1_vld_q;
        out_sof_d = s1_sof_q;
        out_r_d   = out_r_q;
        out_g_d   = out_g_q;
        out_b_d   = out_b_q;
        if (s1_vld_q) begin
            out_r_d = s1_hit_q ? MARK_R : s1_r_q;
            out_g_d = s1_hit_q ? MARK_G : s1_g_q;
            out_b_d = s1_hit_q ? MARK_B : s1_b_q;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_flag_q <= 1'b0;
            marker_x_q  <= '0;
            marker_y_q  <= '0;
            miss_cnt_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            out_vld_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_flag_q <= pend_flag_d;
            marker_x_q  <= marker_x_d;
            marker_y_q  <= marker_y_d;
            miss_cnt_q  <= miss_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_sof_q    <= s1_sof_d;
            s1_hit_q    <= s1_hit_d;
            s1_r_q      <= s1_r_d;
            s1_g_q      <= s1_g_d;
            s1_b_q      <= s1_b_d;
            out_vld_q   <= out_vld_d;
            out_sof_q   <= out_sof_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
        end
    end

    assign red_out   = out_r_q;
    assign green_out = out_g_q;
    assign blue_out  = out_b_q;
    assign out_valid = out_vld_q;
    assign out_sof   = out_sof_q;
    assign tracking  = (state_q == ST_TRACK);
    assign marker_x  = marker_x_q;
    assign marker_y  = marker_y_q;

endmodule
